assoc_cache: RTL and testbench



---
 rtl/assoc_cache.sv | 151 +++++++++++++++
 tb/tb_assoc_cache.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/assoc_cache.sv
// assoc_cache: N-way set-associative write-back, write-allocate cache between a CPU word port and a wide memory port.
// Ports: i_clk / i_rst_n (async, active-low); CPU request (i_cpu_req_*, o_cpu_req_rdy) and read response (o_cpu_resp_*);
// memory command (o_mem_req_val/addr/rw, i_mem_req_rdy), write-back beats (o_mem_req_data_*, i_mem_req_data_ready),
// fill beats (i_mem_resp_val/data, in order, no back-pressure).
module assoc_cache #(
  parameter int WAYS = 2,
  parameter int SETS = 64,
  parameter int LINE_BEATS = 4,
  parameter int CPU_WIDTH = 32,
  parameter int MEM_WIDTH = 128,
  parameter int ADDR_BITS = 30,
  localparam int MA = ADDR_BITS - $clog2(MEM_WIDTH / CPU_WIDTH)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_cpu_req_val,
  output logic                   o_cpu_req_rdy,
  input  logic [ADDR_BITS-1:0]   i_cpu_req_addr,
  input  logic [CPU_WIDTH-1:0]   i_cpu_req_data,
  input  logic [CPU_WIDTH/8-1:0] i_cpu_req_write,
  output logic                   o_cpu_resp_val,
  output logic [CPU_WIDTH-1:0]   o_cpu_resp_data,
  output logic                   o_mem_req_val,
  input  logic                   i_mem_req_rdy,
  output logic [MA-1:0]          o_mem_req_addr,
  output logic                   o_mem_req_rw,
  output logic                   o_mem_req_data_valid,
  input  logic                   i_mem_req_data_ready,
  output logic [MEM_WIDTH-1:0]   o_mem_req_data_bits,
  output logic [MEM_WIDTH/8-1:0] o_mem_req_data_mask,
  input  logic                   i_mem_resp_val,
  input  logic [MEM_WIDTH-1:0]   i_mem_resp_data
);
  localparam int WPB = MEM_WIDTH / CPU_WIDTH;
  localparam int WS = $clog2(WPB);
  localparam int OFF = $clog2(WPB * LINE_BEATS);
  localparam int IDX = $clog2(SETS);
  localparam int TAG = ADDR_BITS - IDX - OFF;
  localparam int BB = $clog2(LINE_BEATS);
  localparam int WW = WAYS > 1 ? $clog2(WAYS) : 1;
  localparam int NB = CPU_WIDTH / 8;
  typedef enum logic [2:0] {IDLE, LOOKUP, WB_REQ, WB_DATA, FILL_REQ, FILL_WAIT} state_t;
  state_t r_state;
  logic [ADDR_BITS-1:0] r_addr;
  logic [CPU_WIDTH-1:0] r_wdata;
  logic [NB-1:0] r_mask;
  logic [WAYS-1:0] r_valid [SETS];
  logic [WAYS-1:0] r_dirty [SETS];
  logic [WW-1:0] r_rr [SETS];
  logic [TAG-1:0] r_tag [WAYS][SETS];
  logic [MEM_WIDTH-1:0] r_line [WAYS][SETS][LINE_BEATS];
  logic [BB-1:0] r_beat;
  logic [WW-1:0] r_vic;
  logic [IDX-1:0] w_idx;
  logic [TAG-1:0] w_tag;
  logic [BB-1:0] w_bsel;
  logic [WS-1:0] w_wsel;
  logic w_hit, w_free_any, w_last;
  logic [WW-1:0] w_way, w_free, w_victim;
  logic [MEM_WIDTH-1:0] w_hline, w_merged;
  logic [CPU_WIDTH-1:0] w_word;
  assign w_idx = r_addr[OFF+IDX-1:OFF];
  assign w_tag = r_addr[ADDR_BITS-1:OFF+IDX];
  assign w_bsel = r_addr[OFF-1:WS];
  assign w_wsel = r_addr[WS-1:0];
  assign w_last = r_beat == BB'(LINE_BEATS - 1);
  always_comb begin
    w_hit = 1'b0;
    w_way = '0;
    for (int w = 0; w < WAYS; w++)
      if (r_valid[w_idx][w] && r_tag[w][w_idx] == w_tag) begin
        w_hit = 1'b1;
        w_way = WW'(w);
      end
    // descending scan so the lowest-index invalid way wins
    w_free_any = 1'b0;
    w_free = '0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (!r_valid[w_idx][w]) begin
        w_free_any = 1'b1;
        w_free = WW'(w);
      end
    w_victim = w_free_any ? w_free : r_rr[w_idx];
    w_hline = r_line[w_way][w_idx][w_bsel];
    w_word = w_hline[int'(w_wsel)*CPU_WIDTH +: CPU_WIDTH];
    w_merged = w_hline;
    for (int b = 0; b < NB; b++)
      if (r_mask[b]) w_merged[int'(w_wsel)*CPU_WIDTH + b*8 +: 8] = r_wdata[b*8 +: 8];
  end
  assign o_cpu_req_rdy = r_state == IDLE;
  assign o_cpu_resp_val = r_state == LOOKUP && w_hit && r_mask == '0;
  assign o_cpu_resp_data = o_cpu_resp_val ? w_word : '0;
  assign o_mem_req_val = r_state == WB_REQ || r_state == FILL_REQ;
  assign o_mem_req_rw = r_state == WB_REQ;
  assign o_mem_req_addr = r_state == WB_REQ ? {r_tag[r_vic][w_idx], w_idx, BB'(0)} :
                          r_state == FILL_REQ ? {w_tag, w_idx, BB'(0)} : '0;
  assign o_mem_req_data_valid = r_state == WB_DATA;
  assign o_mem_req_data_bits = o_mem_req_data_valid ? r_line[r_vic][w_idx][r_beat] : '0;
  assign o_mem_req_data_mask = {(MEM_WIDTH/8){o_mem_req_data_valid}};
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_addr <= '0;
      r_wdata <= '0;
      r_mask <= '0;
      r_beat <= '0;
      r_vic <= '0;
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
        r_rr[s] <= '0;
      end
    end else
      case (r_state)
        IDLE: if (i_cpu_req_val) begin
          r_addr <= i_cpu_req_addr;
          r_wdata <= i_cpu_req_data;
          r_mask <= i_cpu_req_write;
          r_state <= LOOKUP;
        end
        LOOKUP: if (w_hit) begin
          if (|r_mask) r_dirty[w_idx][w_way] <= 1'b1;
          r_state <= IDLE;
        end else begin
          r_vic <= w_victim;
          r_state <= r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim] ? WB_REQ : FILL_REQ;
        end
        WB_REQ: if (i_mem_req_rdy) r_state <= WB_DATA;
        WB_DATA: if (i_mem_req_data_ready) begin
          r_beat <= w_last ? '0 : r_beat + 1'b1;
          if (w_last) r_state <= FILL_REQ;
        end
        FILL_REQ: if (i_mem_req_rdy) r_state <= FILL_WAIT;
        FILL_WAIT: if (i_mem_resp_val) begin
          r_beat <= w_last ? '0 : r_beat + 1'b1;
          if (w_last) begin
            r_valid[w_idx][r_vic] <= 1'b1;
            r_dirty[w_idx][r_vic] <= 1'b0;
            r_rr[w_idx] <= WW'((int'(r_rr[w_idx]) + 1) % WAYS);
            r_state <= LOOKUP;
          end
        end
        default: r_state <= IDLE;
      endcase
  // tag and data arrays need no reset: valid bits gate every use
  always_ff @(posedge i_clk) begin
    if (r_state == FILL_WAIT && i_mem_resp_val) r_line[r_vic][w_idx][r_beat] <= i_mem_resp_data;
    if (r_state == FILL_WAIT && i_mem_resp_val && w_last) r_tag[r_vic][w_idx] <= w_tag;
    if (r_state == LOOKUP && w_hit && |r_mask) r_line[w_way][w_idx][w_bsel] <= w_merged;
  end
endmodule

// File: tb/tb_assoc_cache.sv
// tb_assoc_cache: directed self-checking bench for assoc_cache with a behavioural line memory.
module tb_assoc_cache;
  logic clk = 0;
  always #5 clk = ~clk;
  logic i_rst_n, i_cpu_req_val, o_cpu_req_rdy, o_cpu_resp_val;
  logic [29:0] i_cpu_req_addr;
  logic [31:0] i_cpu_req_data, o_cpu_resp_data;
  logic [3:0] i_cpu_req_write;
  logic o_mem_req_val, i_mem_req_rdy, o_mem_req_rw, o_mem_req_data_valid, i_mem_req_data_ready, i_mem_resp_val;
  logic [27:0] o_mem_req_addr;
  logic [127:0] o_mem_req_data_bits, i_mem_resp_data;
  logic [15:0] o_mem_req_data_mask;
  assoc_cache dut (
    .i_clk(clk), .i_rst_n(i_rst_n),
    .i_cpu_req_val(i_cpu_req_val), .o_cpu_req_rdy(o_cpu_req_rdy),
    .i_cpu_req_addr(i_cpu_req_addr), .i_cpu_req_data(i_cpu_req_data), .i_cpu_req_write(i_cpu_req_write),
    .o_cpu_resp_val(o_cpu_resp_val), .o_cpu_resp_data(o_cpu_resp_data),
    .o_mem_req_val(o_mem_req_val), .i_mem_req_rdy(i_mem_req_rdy), .o_mem_req_addr(o_mem_req_addr),
    .o_mem_req_rw(o_mem_req_rw), .o_mem_req_data_valid(o_mem_req_data_valid),
    .i_mem_req_data_ready(i_mem_req_data_ready), .o_mem_req_data_bits(o_mem_req_data_bits),
    .o_mem_req_data_mask(o_mem_req_data_mask), .i_mem_resp_val(i_mem_resp_val), .i_mem_resp_data(i_mem_resp_data)
  );
  int checks = 0, errors = 0, cyc = 0;
  int req_stall = 0, data_stall = 0, rq_n = 0, dt_n = 0, stalls = 0;
  int fill_left = 0, fill_ptr = 0, fill_addr = 0, n_fill = 0, n_wb = 0, wb_addr = 0, wb_k = 0, wb_k_at_fill = 0;
  int last_beat_cyc = 0, resp_cyc = 0;
  logic [27:0] h_addr;
  logic h_rw;
  logic [127:0] h_data;
  logic [127:0] wb_beats [4];
  logic [127:0] mem_over [int];
  always @(posedge clk) cyc <= cyc + 1;
  // backing store: byte k of word a is (4a+k) mod 256, top byte xored with a[11:8]<<4
  function automatic logic [31:0] word(int a);
    logic [7:0] b;
    logic [3:0] h;
    b = 8'(4 * a);
    h = 4'(a >> 8);
    return {(b + 8'd3) ^ {h, 4'h0}, b + 8'd2, b + 8'd1, b};
  endfunction
  function automatic logic [127:0] beat(int m);
    if (mem_over.exists(m)) return mem_over[m];
    return {word(4*m+3), word(4*m+2), word(4*m+1), word(4*m)};
  endfunction
  initial begin
    i_mem_req_rdy = 0; i_mem_req_data_ready = 0; i_mem_resp_val = 0; i_mem_resp_data = '0;
    forever begin
      @(negedge clk);
      i_mem_resp_val = 0; i_mem_req_rdy = 0; i_mem_req_data_ready = 0;
      if (!i_rst_n) begin
        fill_left = 0; rq_n = 0; dt_n = 0;
      end else if (fill_left > 0) begin
        i_mem_resp_val = 1; i_mem_resp_data = beat(fill_ptr); fill_ptr++; fill_left--;
        if (fill_left == 0) last_beat_cyc = cyc;
      end else begin
        if (o_mem_req_val) begin
          if (rq_n > 0) begin
            checks++;
            if ({o_mem_req_addr, o_mem_req_rw} !== {h_addr, h_rw}) begin
              errors++; $display("FAIL req_hold: got %h/%b want %h/%b", o_mem_req_addr, o_mem_req_rw, h_addr, h_rw);
            end
          end else begin
            h_addr = o_mem_req_addr; h_rw = o_mem_req_rw;
          end
          if (rq_n < req_stall) begin
            rq_n++; stalls++;
          end else begin
            i_mem_req_rdy = 1; rq_n = 0;
            if (o_mem_req_rw) begin
              n_wb++; wb_addr = int'(o_mem_req_addr); wb_k = 0;
            end else begin
              n_fill++; fill_addr = int'(o_mem_req_addr); fill_ptr = fill_addr; fill_left = 4; wb_k_at_fill = wb_k;
            end
          end
        end
        if (o_mem_req_data_valid) begin
          if (dt_n > 0) begin
            checks++;
            if (o_mem_req_data_bits !== h_data) begin
              errors++; $display("FAIL data_hold: got %h want %h", o_mem_req_data_bits, h_data);
            end
          end else h_data = o_mem_req_data_bits;
          if (dt_n < data_stall) begin
            dt_n++; stalls++;
          end else begin
            i_mem_req_data_ready = 1; dt_n = 0;
            checks++;
            if (o_mem_req_data_mask !== 16'hFFFF) begin
              errors++; $display("FAIL wb_mask: got %h want ffff", o_mem_req_data_mask);
            end
            if (wb_k < 4) wb_beats[wb_k] = o_mem_req_data_bits;
            mem_over[wb_addr + wb_k] = o_mem_req_data_bits;
            wb_k++;
          end
        end
      end
    end
  end
  task automatic cpu(input logic [29:0] a, input logic [31:0] d, input logic [3:0] m,
                     output logic [31:0] rd, output int lat, output logic rv);
    int g = 0;
    @(negedge clk);
    while (!o_cpu_req_rdy && g < 2000) begin @(negedge clk); g++; end
    checks++;
    if (g >= 2000) begin errors++; $display("FAIL rdy_timeout: got rdy=0 want 1"); end
    i_cpu_req_val = 1; i_cpu_req_addr = a; i_cpu_req_data = d; i_cpu_req_write = m;
    @(negedge clk);
    i_cpu_req_val = 0;
    lat = 1;
    rv = o_cpu_resp_val;
    while (m == 0 && !o_cpu_resp_val && lat < 2000) begin @(negedge clk); lat++; end
    rd = o_cpu_resp_data;
    resp_cyc = cyc;
  endtask
  task automatic test_reset;
    i_rst_n = 0; i_cpu_req_val = 0; i_cpu_req_addr = '0; i_cpu_req_data = '0; i_cpu_req_write = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_cpu_req_rdy, o_cpu_resp_val, o_mem_req_val, o_mem_req_rw, o_mem_req_data_valid} !== 5'b10000) begin
      errors++; $display("FAIL reset_ctl: got %b want 10000", {o_cpu_req_rdy, o_cpu_resp_val, o_mem_req_val, o_mem_req_rw, o_mem_req_data_valid});
    end
    checks++;
    if ({o_cpu_resp_data, o_mem_req_addr, o_mem_req_data_bits, o_mem_req_data_mask} !== '0) begin
      errors++; $display("FAIL reset_bus: got %h want 0", {o_cpu_resp_data, o_mem_req_addr, o_mem_req_data_bits, o_mem_req_data_mask});
    end
    i_rst_n = 1;
  endtask
  task automatic test_cold_miss;
    logic [31:0] rd; int lat; logic rv;
    cpu(30'h040, 0, 0, rd, lat, rv);
    checks++; if (rd !== 32'h03020100) begin errors++; $display("FAIL cold_data: got %h want 03020100", rd); end
    checks++; if (n_fill !== 1 || fill_addr !== 'h010) begin errors++; $display("FAIL cold_fill: got n=%0d addr=%h want 1/010", n_fill, fill_addr); end
    checks++; if (n_wb !== 0) begin errors++; $display("FAIL cold_wb: got %0d want 0", n_wb); end
    checks++; if (fill_ptr - fill_addr !== 4) begin errors++; $display("FAIL cold_beats: got %0d want 4", fill_ptr - fill_addr); end
    checks++; if (resp_cyc !== last_beat_cyc + 1) begin errors++; $display("FAIL cold_latency: got %0d want %0d", resp_cyc, last_beat_cyc + 1); end
  endtask
  task automatic test_hit;
    logic [31:0] rd; int lat; logic rv;
    cpu(30'h041, 0, 0, rd, lat, rv);
    checks++; if (rd !== 32'h07060504) begin errors++; $display("FAIL hit_data: got %h want 07060504", rd); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL hit_latency: got %0d want 1", lat); end
    checks++; if (n_fill !== 1 || n_wb !== 0) begin errors++; $display("FAIL hit_traffic: got %0d/%0d want 1/0", n_fill, n_wb); end
    @(negedge clk);
    checks++; if ({o_cpu_req_rdy, o_cpu_resp_val} !== 2'b10) begin errors++; $display("FAIL hit_t2: got %b want 10", {o_cpu_req_rdy, o_cpu_resp_val}); end
  endtask
  task automatic test_write;
    logic [31:0] rd; int lat; logic rv;
    cpu(30'h040, 32'hAAAABBBB, 4'h3, rd, lat, rv);
    checks++; if (rv !== 1'b0) begin errors++; $display("FAIL write_resp: got %b want 0", rv); end
    cpu(30'h043, 32'h12345678, 4'hC, rd, lat, rv);
    cpu(30'h040, 0, 0, rd, lat, rv);
    checks++; if (rd !== 32'h0302BBBB) begin errors++; $display("FAIL write_lo: got %h want 0302bbbb", rd); end
    cpu(30'h043, 0, 0, rd, lat, rv);
    checks++; if (rd !== 32'h12340D0C) begin errors++; $display("FAIL write_hi: got %h want 12340d0c", rd); end
    checks++; if (n_fill !== 1) begin errors++; $display("FAIL write_traffic: got %0d want 1", n_fill); end
  endtask
  task automatic test_evict;
    logic [31:0] rd; int lat; logic rv;
    cpu(30'h440, 0, 0, rd, lat, rv);
    checks++; if (rd !== 32'h43020100 || fill_addr !== 'h110 || n_wb !== 0) begin
      errors++; $display("FAIL evict_way1: got %h/%h/%0d want 43020100/110/0", rd, fill_addr, n_wb);
    end
    cpu(30'h840, 0, 0, rd, lat, rv);
    checks++; if (rd !== 32'h83020100) begin errors++; $display("FAIL evict_data: got %h want 83020100", rd); end
    checks++; if (n_wb !== 1 || wb_addr !== 'h010 || wb_k !== 4) begin errors++; $display("FAIL evict_wb: got %0d/%h/%0d want 1/010/4", n_wb, wb_addr, wb_k); end
    checks++; if (fill_addr !== 'h210 || wb_k_at_fill !== 4) begin errors++; $display("FAIL evict_fill: got %h/%0d want 210/4", fill_addr, wb_k_at_fill); end
    checks++; if (wb_beats[0] !== 128'h12340D0C_0B0A0908_07060504_0302BBBB) begin errors++; $display("FAIL evict_beat0: got %h", wb_beats[0]); end
    checks++; if (wb_beats[3] !== 128'h3F3E3D3C_3B3A3938_37363534_33323130) begin errors++; $display("FAIL evict_beat3: got %h", wb_beats[3]); end
    cpu(30'h040, 0, 0, rd, lat, rv);
    checks++; if (rd !== 32'h0302BBBB || n_wb !== 1 || fill_addr !== 'h010) begin
      errors++; $display("FAIL evict_reload: got %h/%0d/%h want 0302bbbb/1/010", rd, n_wb, fill_addr);
    end
  endtask
  task automatic test_back_to_back_stall;
    logic [31:0] rd; int lat; logic rv;
    logic [127:0] exp [4];
    exp[0] = 128'h8F0E0D0C_8B0A0908_DEADBEEF_83020100;
    exp[1] = 128'h9F1E1D1C_9B1A1918_97161514_93121110;
    exp[2] = 128'hAF2E2D2C_AB2A2928_A7262524_A3222120;
    exp[3] = 128'hBF3E3D3C_BB3A3938_B7363534_B3323130;
    cpu(30'h841, 32'hDEADBEEF, 4'hF, rd, lat, rv);
    req_stall = 10; data_stall = 10; stalls = 0;
    cpu(30'hC40, 0, 0, rd, lat, rv);
    req_stall = 0; data_stall = 0;
    checks++; if (rd !== 32'hC3020100) begin errors++; $display("FAIL stall_data: got %h want c3020100", rd); end
    checks++; if (stalls !== 60) begin errors++; $display("FAIL stall_cycles: got %0d want 60", stalls); end
    checks++; if (n_wb !== 2 || wb_addr !== 'h210 || wb_k !== 4) begin errors++; $display("FAIL stall_wb: got %0d/%h/%0d want 2/210/4", n_wb, wb_addr, wb_k); end
    checks++; if (fill_addr !== 'h310) begin errors++; $display("FAIL stall_fill: got %h want 310", fill_addr); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (wb_beats[k] !== exp[k]) begin errors++; $display("FAIL stall_beat%0d: got %h want %h", k, wb_beats[k], exp[k]); end
    end
  endtask
  task automatic test_reset_mid;
    logic [31:0] rd; int lat; logic rv; int nf, nw, g;
    @(negedge clk);
    i_cpu_req_val = 1; i_cpu_req_addr = 30'h480; i_cpu_req_write = 0;
    @(negedge clk);
    i_cpu_req_val = 0;
    g = 0;
    while (fill_left != 2 && g < 100) begin @(negedge clk); #1; g++; end
    checks++; if (fill_left !== 2) begin errors++; $display("FAIL mid_reach: got %0d want 2", fill_left); end
    i_rst_n = 0;
    #1;
    checks++;
    if ({o_cpu_req_rdy, o_cpu_resp_val, o_mem_req_val, o_mem_req_rw, o_mem_req_data_valid} !== 5'b10000) begin
      errors++; $display("FAIL mid_ctl: got %b want 10000", {o_cpu_req_rdy, o_cpu_resp_val, o_mem_req_val, o_mem_req_rw, o_mem_req_data_valid});
    end
    checks++;
    if ({o_cpu_resp_data, o_mem_req_addr, o_mem_req_data_bits, o_mem_req_data_mask} !== '0) begin
      errors++; $display("FAIL mid_bus: got %h want 0", {o_cpu_resp_data, o_mem_req_addr, o_mem_req_data_bits, o_mem_req_data_mask});
    end
    nf = n_fill; nw = n_wb;
    repeat (3) @(negedge clk);
    #1 i_rst_n = 1;
    repeat (8) @(negedge clk);
    checks++; if (n_fill !== nf || n_wb !== nw || o_mem_req_val !== 1'b0) begin
      errors++; $display("FAIL mid_quiet: got %0d/%0d/%b want %0d/%0d/0", n_fill, n_wb, o_mem_req_val, nf, nw);
    end
    cpu(30'h040, 0, 0, rd, lat, rv);
    checks++; if (n_fill !== nf + 1 || fill_addr !== 'h010) begin errors++; $display("FAIL mid_miss: got %0d/%h want %0d/010", n_fill, fill_addr, nf + 1); end
    checks++; if (rd !== 32'h0302BBBB) begin errors++; $display("FAIL mid_data: got %h want 0302bbbb", rd); end
  endtask
  initial begin
    test_reset;
    test_cold_miss;
    test_hit;
    test_write;
    test_evict;
    test_back_to_back_stall;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
